// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared encodings for the pipeline hazard unit
package hazard_unit_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Bit positions inside the {rs2,rs1,rd} validity vector from decode
    localparam int VR_RD  = 0;
    localparam int VR_RS1 = 1;
    localparam int VR_RS2 = 2;

    // Winning hazard action for the current cycle, in priority order
    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_EXT      = 2'd1,
        HZ_REDIRECT = 2'd2,
        HZ_LOADUSE  = 2'd3
    } hz_act_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - EX operand forwarding select for one source
module hazard_fwd_sel
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_v,
    input  logic                  mem_v,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_v,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired, so a write to it can never be a forwarding source
    assign mem_hit = src_v & mem_v & mem_regwrite & (mem_rd == src) & (mem_rd != '0);
    assign wb_hit  = src_v & wb_v  & wb_regwrite  & (wb_rd  == src) & (wb_rd  != '0);

    // Youngest producer wins: MEM before WB
    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, redirect flush and forwarding control
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ID_Valid,
    input  logic [REG_ADDR_W-1:0] ID_rs1,
    input  logic [REG_ADDR_W-1:0] ID_rs2,
    input  logic [REG_ADDR_W-1:0] ID_rd,
    input  logic [2:0]            ID_ValidReg,
    input  logic                  ID_RegWrite,
    input  logic                  ID_MemRead,
    input  logic                  Redirect,
    input  logic                  ExtStall,
    output logic                  Stall,
    output logic                  FlushIFID,
    output logic                  FlushIDEX,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic [CNT_W-1:0]      StallCount
);

    // EX stage record
    logic                  ex_v;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic                  ex_rs1v;
    logic                  ex_rs2v;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_rw;
    logic                  ex_mr;
    // MEM stage record
    logic                  mem_v;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_rw;
    logic                  mem_mr;
    // WB stage record
    logic                  wb_v;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_rw;

    logic                  lu;
    hz_act_e               act;
    logic [CNT_W-1:0]      stall_cnt;

    // Destination validity is implied by RegWrite; the decode bit is not needed here
    logic unused_vr_rd;
    assign unused_vr_rd = ID_ValidReg[VR_RD];

    // Load in EX whose result a valid ID source needs: one bubble required
    assign lu = ID_Valid & ex_v & ex_mr & ex_rw & (ex_rd != '0) &
                ((ID_ValidReg[VR_RS1] & (ID_rs1 == ex_rd)) |
                 (ID_ValidReg[VR_RS2] & (ID_rs2 == ex_rd)));

    // Resolve the single winning action: freeze, then redirect, then load-use
    always_comb begin
        act = HZ_NONE;
        if (ExtStall) begin
            act = HZ_EXT;
        end else if (Redirect) begin
            act = HZ_REDIRECT;
        end else if (lu) begin
            act = HZ_LOADUSE;
        end
    end

    // Decode the action into the pipeline control strobes
    always_comb begin
        Stall     = 1'b0;
        FlushIFID = 1'b0;
        FlushIDEX = 1'b0;
        case (act)
            HZ_EXT: begin
                Stall = 1'b1;
            end
            HZ_REDIRECT: begin
                FlushIFID = 1'b1;
                FlushIDEX = 1'b1;
            end
            HZ_LOADUSE: begin
                Stall     = 1'b1;
                FlushIDEX = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Advance the in-flight records unless the whole pipeline is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v    <= 1'b0;
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            ex_rs1v <= 1'b0;
            ex_rs2v <= 1'b0;
            ex_rd   <= '0;
            ex_rw   <= 1'b0;
            ex_mr   <= 1'b0;
            mem_v   <= 1'b0;
            mem_rd  <= '0;
            mem_rw  <= 1'b0;
            mem_mr  <= 1'b0;
            wb_v    <= 1'b0;
            wb_rd   <= '0;
            wb_rw   <= 1'b0;
        end else if (!ExtStall) begin
            wb_v    <= mem_v;
            wb_rd   <= mem_rd;
            wb_rw   <= mem_rw;
            mem_v   <= ex_v;
            mem_rd  <= ex_rd;
            mem_rw  <= ex_rw;
            mem_mr  <= ex_mr;
            ex_v    <= ID_Valid & ~FlushIDEX;
            ex_rs1  <= ID_rs1;
            ex_rs2  <= ID_rs2;
            ex_rs1v <= ID_ValidReg[VR_RS1];
            ex_rs2v <= ID_ValidReg[VR_RS2];
            ex_rd   <= ID_rd;
            ex_rw   <= ID_RegWrite;
            ex_mr   <= ID_MemRead;
        end
    end

    // Count load-use bubbles, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((act == HZ_LOADUSE) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt;

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src          (ex_rs1),
        .src_v        (ex_v & ex_rs1v),
        .mem_v        (mem_v),
        .mem_regwrite (mem_rw),
        .mem_rd       (mem_rd),
        .wb_v         (wb_v),
        .wb_regwrite  (wb_rw),
        .wb_rd        (wb_rd),
        .sel          (ForwardA)
    );

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src          (ex_rs2),
        .src_v        (ex_v & ex_rs2v),
        .mem_v        (mem_v),
        .mem_regwrite (mem_rw),
        .mem_rd       (mem_rd),
        .wb_v         (wb_v),
        .wb_regwrite  (wb_rw),
        .wb_rd        (wb_rd),
        .sel          (ForwardB)
    );

    // A load in MEM feeding EX means a missed load-use bubble upstream
    a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_v & mem_v & mem_mr & mem_rw & (mem_rd != '0) &
          ((ex_rs1v & (ex_rs1 == mem_rd)) | (ex_rs2v & (ex_rs2 == mem_rd)))));

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit
module tb_hazard_unit;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] vr;
        logic       rw;
        logic       mr;
    } ins_t;

    typedef struct packed {
        logic       stall;
        logic       fifd;
        logic       fidx;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ID_Valid;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic [4:0] ID_rd;
    logic [2:0] ID_ValidReg;
    logic       ID_RegWrite;
    logic       ID_MemRead;
    logic       Redirect;
    logic       ExtStall;
    logic       Stall;
    logic       FlushIFID;
    logic       FlushIDEX;
    logic [1:0] ForwardA;
    logic [1:0] ForwardB;
    logic [3:0] StallCount;

    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];
    logic [3:0] exp_cnt;

    hazard_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ID_Valid    (ID_Valid),
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .ID_rd       (ID_rd),
        .ID_ValidReg (ID_ValidReg),
        .ID_RegWrite (ID_RegWrite),
        .ID_MemRead  (ID_MemRead),
        .Redirect    (Redirect),
        .ExtStall    (ExtStall),
        .Stall       (Stall),
        .FlushIFID   (FlushIFID),
        .FlushIDEX   (FlushIDEX),
        .ForwardA    (ForwardA),
        .ForwardB    (ForwardB),
        .StallCount  (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ins_t nop();
        ins_t i;
        i = '0;
        return i;
    endfunction

    function automatic ins_t ld(input logic [4:0] rd, input logic [4:0] rs1);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.vr = 3'b011; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.vr = 3'b111; i.rw = 1'b1;
        return i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic score(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".stall"}, 32'(Stall),      32'(e.stall));
            check({tag, ".fifd"},  32'(FlushIFID),  32'(e.fifd));
            check({tag, ".fidx"},  32'(FlushIDEX),  32'(e.fidx));
            check({tag, ".fa"},    32'(ForwardA),   32'(e.fa));
            check({tag, ".fb"},    32'(ForwardB),   32'(e.fb));
            check({tag, ".cnt"},   32'(StallCount), 32'(e.cnt));
        end
    endtask

    task automatic push_exp(input logic s, input logic ff, input logic fx,
                            input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] c);
        exp_t e;
        e.stall = s; e.fifd = ff; e.fidx = fx; e.fa = fa; e.fb = fb; e.cnt = c;
        exp_q.push_back(e);
    endtask

    task automatic step(input string tag, input ins_t i, input logic redir, input logic ext,
                        input logic s, input logic ff, input logic fx,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] c);
        @(posedge clk);
        #1;
        ID_Valid    = i.v;
        ID_rd       = i.rd;
        ID_rs1      = i.rs1;
        ID_rs2      = i.rs2;
        ID_ValidReg = i.vr;
        ID_RegWrite = i.rw;
        ID_MemRead  = i.mr;
        Redirect    = redir;
        ExtStall    = ext;
        push_exp(s, ff, fx, fa, fb, c);
        #2;
        score(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ID_Valid = 1'b0; ID_rd = '0; ID_rs1 = '0; ID_rs2 = '0;
        ID_ValidReg = '0; ID_RegWrite = 1'b0; ID_MemRead = 1'b0;
        Redirect = 1'b0; ExtStall = 1'b0;
        #3;
        push_exp(0, 0, 0, 0, 0, 0);
        score("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // load x5 ; add x6,x5,x7 : one bubble then WB forward
        step("lu.ld",    ld(5'd5, 5'd1),          0, 0, 0, 0, 0, 0, 0, 0);
        step("lu.stall", alu(5'd6, 5'd5, 5'd7),   0, 0, 1, 0, 1, 0, 0, 0);
        step("lu.held",  alu(5'd6, 5'd5, 5'd7),   0, 0, 0, 0, 0, 0, 0, 1);
        step("lu.fwd",   nop(),                   0, 0, 0, 0, 0, 2, 0, 1);
        step("lu.n1",    nop(),                   0, 0, 0, 0, 0, 0, 0, 1);
        step("lu.n2",    nop(),                   0, 0, 0, 0, 0, 0, 0, 1);

        // add x3,x1,x2 ; sub x4,x3,x3 back to back, then with a gap
        step("b2b.add",  alu(5'd3, 5'd1, 5'd2),   0, 0, 0, 0, 0, 0, 0, 1);
        step("b2b.sub",  alu(5'd4, 5'd3, 5'd3),   0, 0, 0, 0, 0, 0, 0, 1);
        step("b2b.fwd",  nop(),                   0, 0, 0, 0, 0, 1, 1, 1);
        step("b2b.n1",   nop(),                   0, 0, 0, 0, 0, 0, 0, 1);
        step("gap.add",  alu(5'd3, 5'd1, 5'd2),   0, 0, 0, 0, 0, 0, 0, 1);
        step("gap.nop",  nop(),                   0, 0, 0, 0, 0, 0, 0, 1);
        step("gap.sub",  alu(5'd4, 5'd3, 5'd3),   0, 0, 0, 0, 0, 0, 0, 1);
        step("gap.fwd",  nop(),                   0, 0, 0, 0, 0, 2, 2, 1);
        step("gap.n1",   nop(),                   0, 0, 0, 0, 0, 0, 0, 1);
        step("gap.n2",   nop(),                   0, 0, 0, 0, 0, 0, 0, 1);

        // x0 producer never stalls or forwards
        step("x0.ld",    ld(5'd0, 5'd1),          0, 0, 0, 0, 0, 0, 0, 1);
        step("x0.use",   alu(5'd8, 5'd0, 5'd0),   0, 0, 0, 0, 0, 0, 0, 1);
        step("x0.fwd",   nop(),                   0, 0, 0, 0, 0, 0, 0, 1);
        step("x0.n1",    nop(),                   0, 0, 0, 0, 0, 0, 0, 1);

        // redirect beats load-use; counter untouched
        step("rd.ld",    ld(5'd9, 5'd1),          0, 0, 0, 0, 0, 0, 0, 1);
        step("rd.hit",   alu(5'd10, 5'd9, 5'd9),  1, 0, 0, 1, 1, 0, 0, 1);
        step("rd.after", nop(),                   0, 0, 0, 0, 0, 0, 0, 1);
        step("rd.n1",    nop(),                   0, 0, 0, 0, 0, 0, 0, 1);

        // external freeze for 3 cycles inside a MEM forward pair
        step("ext.add",  alu(5'd11, 5'd1, 5'd2),  0, 0, 0, 0, 0, 0, 0, 1);
        step("ext.sub",  alu(5'd12, 5'd11, 5'd2), 0, 0, 0, 0, 0, 0, 0, 1);
        step("ext.f1",   nop(),                   0, 1, 1, 0, 0, 1, 0, 1);
        step("ext.f2",   nop(),                   0, 1, 1, 0, 0, 1, 0, 1);
        step("ext.f3",   nop(),                   0, 1, 1, 0, 0, 1, 0, 1);
        step("ext.rel",  nop(),                   0, 0, 0, 0, 0, 1, 0, 1);
        step("ext.adv",  nop(),                   0, 0, 0, 0, 0, 0, 0, 1);

        // freeze over a load-use: no count, no bubble until released
        step("el.ld",    ld(5'd13, 5'd1),         0, 0, 0, 0, 0, 0, 0, 1);
        step("el.frz",   ld(5'd14, 5'd13),        0, 1, 1, 0, 0, 0, 0, 1);
        step("el.lu",    ld(5'd14, 5'd13),        0, 0, 1, 0, 1, 0, 0, 1);
        step("el.held",  ld(5'd14, 5'd13),        0, 0, 0, 0, 0, 0, 0, 2);
        step("el.fwd",   nop(),                   0, 0, 0, 0, 0, 2, 0, 2);
        step("el.n1",    nop(),                   0, 0, 0, 0, 0, 0, 0, 2);

        // drive the counter to all-ones and past it
        exp_cnt = 4'd2;
        for (int k = 0; k < 15; k++) begin
            step("sat.ld",   ld(5'd15, 5'd1),         0, 0, 0, 0, 0, 0, 0, exp_cnt);
            step("sat.lu",   alu(5'd16, 5'd15, 5'd15), 0, 0, 1, 0, 1, 0, 0, exp_cnt);
            exp_cnt = (exp_cnt == 4'hf) ? 4'hf : exp_cnt + 4'd1;
            step("sat.held", alu(5'd16, 5'd15, 5'd15), 0, 0, 0, 0, 0, 0, 0, exp_cnt);
            step("sat.fwd",  nop(),                    0, 0, 0, 0, 0, 2, 2, exp_cnt);
            step("sat.n1",   nop(),                    0, 0, 0, 0, 0, 0, 0, exp_cnt);
        end
        check("sat.final", 32'(StallCount), 32'd15);

        // asynchronous reset in the middle of a stall
        step("ar.ld",    ld(5'd17, 5'd1),         0, 0, 0, 0, 0, 0, 0, 4'hf);
        step("ar.stall", alu(5'd18, 5'd17, 5'd17), 0, 0, 1, 0, 1, 0, 0, 4'hf);
        #1;
        rst_n = 1'b0;
        #1;
        push_exp(0, 0, 0, 0, 0, 0);
        score("ar.async");
        @(negedge clk);
        rst_n = 1'b1;
        step("ar.post",  alu(5'd18, 5'd17, 5'd17), 0, 0, 0, 0, 0, 0, 0, 0);
        step("ar.ex",    nop(),                   0, 0, 0, 0, 0, 0, 0, 0);

        check("queue.empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumes the per-instruction control bundle produced by the decode-stage control unit: ValidReg, RegWrite, MemRead, Branch, Jump and the register fields.
- Tracks in-flight destination registers through the EX, MEM and WB stages of the 5-stage pipeline.
- From that state it produces load-use stalls, control-hazard flushes and EX-stage operand forwarding selects.
- Keeps a saturating count of hazard stall cycles.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 32, stall counter width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous, active-low
ID_Valid  in  1  ID stage holds a real instruction
ID_rs1  in  REG_ADDR_W  ID source 1 index
ID_rs2  in  REG_ADDR_W  ID source 2 index
ID_rd  in  REG_ADDR_W  ID destination index
ID_ValidReg  in  3  {rs2,rs1,rd} validity from decode
ID_RegWrite  in  1  decode RegWrite
ID_MemRead  in  1  decode MemRead
Redirect  in  1  EX resolved taken branch or jump this cycle
ExtStall  in  1  external freeze (memory wait)
Stall  out  1  hold PC and IF/ID register
FlushIFID  out  1  zero IF/ID register at next edge
FlushIDEX  out  1  insert bubble into ID/EX at next edge
ForwardA  out  2  EX operand 1 source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
ForwardB  out  2  EX operand 2 source, same encoding
StallCount  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Internal stage records:
  - EX: V, rs1, rs2, rs1v, rs2v, rd, RegWrite, MemRead.
  - MEM: V, rd, RegWrite, MemRead.
  - WB: V, rd, RegWrite.
- Reset (rst_n=0, asynchronous):
  - All V bits and StallCount cleared.
  - All outputs therefore 0: Stall, FlushIFID, FlushIDEX, ForwardA, ForwardB, StallCount.
- "Writes r" means V & RegWrite & rd==r & r!=0. Index 0 never creates a hazard or a forward.
- Load-use hazard (combinational, LU):
  - Condition: ID_Valid & EX.V & EX.MemRead & EX.RegWrite & EX.rd!=0.
  - Plus either (ID_ValidReg[1] & ID_rs1==EX.rd) or (ID_ValidReg[2] & ID_rs2==EX.rd).
- Output priority, combinational:
  1. ExtStall=1: Stall=1, FlushIFID=0, FlushIDEX=0. All stage records hold. StallCount holds.
  2. Redirect=1: FlushIFID=1, FlushIDEX=1, Stall=0. LU is ignored. Counter does not increment.
  3. LU=1: Stall=1, FlushIDEX=1, FlushIFID=0. StallCount increments by 1 and saturates at all-ones.
  4. Otherwise all three outputs are 0.
- Stage advance at the rising edge when ExtStall=0:
  - WB<=MEM.
  - MEM<=EX.
  - EX<=ID fields, with EX.V=ID_Valid & ~FlushIDEX.
  - rs1v/rs2v are taken from ID_ValidReg[1]/[2].
- Latency:
  - A load-use stall lasts exactly one cycle.
  - After the stall the load sits in WB while the consumer is in EX, so the consumer is served by ForwardX=2.
- Forwarding (combinational, from EX record):
  - ForwardA=1 if MEM writes EX.rs1 & EX.rs1v & EX.V.
  - Else ForwardA=2 if WB writes EX.rs1 & EX.rs1v & EX.V.
  - Else ForwardA=0.
  - ForwardB is identical using rs2/rs2v.
  - MEM has priority over WB (youngest value wins).
- Forwards are computed even under ExtStall, so they stay consistent with the held EX contents.
- A MEM.MemRead producer matching the EX sources must never occur. This is an assertion, not handled in logic.
- FENCE and S/B instructions (RegWrite=0) never produce forwards or stalls as producers. They do act as consumers per ValidReg.
- Mid-operation reset clears all records. The first post-reset instructions see no hazards.

Decomposition:
- Shared package holds:
  - FWD_RF=0, FWD_MEM=1, FWD_WB=2.
  - The ValidReg bit positions: VR_RD=0, VR_RS1=1, VR_RS2=2.
- One sub-module, hazard_fwd_sel, is natural. It is purely combinational, taking the source index, its valid bit, and the MEM/WB records, and returning the 2-bit select. It is instantiated twice, for A and B.
- Stage records and the counter stay in hazard_unit.

Test Plan:
- Load x5 followed by add x6,x5,x7:
  - Cycle of the add in ID: Stall=1, FlushIDEX=1, StallCount 0->1.
  - Next cycle: Stall=0.
  - Add in EX: ForwardA=2.
- add x3,x1,x2 followed by sub x4,x3,x3: with sub in EX, ForwardA=1 and ForwardB=1. With a one-instruction gap instead, both are 2.
- Producer writing x0, then consumer reading x0: Stall=0, ForwardA=0, ForwardB=0.
- Redirect=1 in the same cycle as a load-use match: FlushIFID=1, FlushIDEX=1, Stall=0, StallCount unchanged.
- ExtStall=1 for 3 cycles in the middle of a forwarding pair:
  - Stage records frozen, Stall=1, ForwardA stable at 1.
  - After release, the pipeline advances normally.
- Force StallCount to all-ones, then trigger a load-use: it stays all-ones.
- Assert rst_n=0 asynchronously mid-stall: all outputs go to 0 immediately, without waiting for a clock edge.
